// File: rtl/seq_serializer.sv
// seq_serializer
//   Takes variable-length bit strings over a valid/ready handshake and
//   shifts them out MSB-first, one bit per clock, on a registered serial
//   line. This line feeds the serial pattern detector. One word can wait
//   in a pending buffer while the current word is shifted out, so
//   consecutive words leave back to back with no gap. Between words the
//   line sits at IDLE_BIT.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high, clears all state
//   flush       synchronous abort of the pending word and the in-flight word
//   load_valid  load_data/load_len are valid
//   load_ready  a word can be accepted this cycle
//   load_data   string bits; bits [L-1:0] are used
//   load_len    word length L; 0 means WIDTH
//   seq_out     registered serial bit
//   bit_valid   seq_out carries a data bit
//   word_last   seq_out carries bit 0 of the current word
//   busy        shifter active or pending buffer full
//   words_sent  number of completed words, wraps modulo 256
module seq_serializer #(
  parameter int   WIDTH    = 16,
  parameter int   LW       = $clog2(WIDTH),
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LW-1:0]    load_len,
  output logic             seq_out,
  output logic             bit_valid,
  output logic             word_last,
  output logic             busy,
  output logic [7:0]       words_sent
);

  logic [WIDTH-1:0] pend_data;
  logic [LW:0]      pend_len;   // 1..WIDTH
  logic             pend_valid;
  logic [WIDTH-1:0] sh;
  logic [LW:0]      cnt;        // bits remaining, including the one on seq_out

  logic          active;
  logic          cnt_is_one;
  logic          move;
  logic          accept;
  logic [LW:0]   load_len_ext;
  logic [LW-1:0] pend_msb_idx;
  logic [LW-1:0] sh_next_idx;

  assign active     = (cnt != '0);
  assign cnt_is_one = (cnt == (LW+1)'(1));
  assign move       = pend_valid && (!active || cnt_is_one);
  assign load_ready = !flush && (!pend_valid || move);
  assign accept     = load_valid && load_ready;
  assign busy       = active || pend_valid;

  assign load_len_ext = (load_len == '0) ? (LW+1)'(WIDTH) : {1'b0, load_len};

  // Both indices wrap in LW bits. A stored length of WIDTH has zero low
  // bits, so subtracting from those bits still gives the right bit
  // position.
  assign pend_msb_idx = pend_len[LW-1:0] - LW'(1);
  assign sh_next_idx  = cnt[LW-1:0] - LW'(2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_data  <= '0;
      pend_len   <= '0;
      pend_valid <= 1'b0;
      sh         <= '0;
      cnt        <= '0;
      seq_out    <= IDLE_BIT;
      bit_valid  <= 1'b0;
      word_last  <= 1'b0;
      words_sent <= '0;
    end else if (flush) begin
      pend_valid <= 1'b0;
      cnt        <= '0;
      seq_out    <= IDLE_BIT;
      bit_valid  <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      if (word_last)
        words_sent <= words_sent + 8'd1;

      if (move) begin
        sh        <= pend_data;
        cnt       <= pend_len;
        seq_out   <= pend_data[pend_msb_idx];
        bit_valid <= 1'b1;
        word_last <= (pend_len == (LW+1)'(1));
      end else if (active) begin
        if (cnt_is_one) begin
          cnt       <= '0;
          seq_out   <= IDLE_BIT;
          bit_valid <= 1'b0;
          word_last <= 1'b0;
        end else begin
          cnt       <= cnt - (LW+1)'(1);
          seq_out   <= sh[sh_next_idx];
          word_last <= (cnt == (LW+1)'(2));
        end
      end

      // A new word may enter the buffer in the same cycle the old one leaves it.
      if (accept) begin
        pend_data  <= load_data;
        pend_len   <= load_len_ext;
        pend_valid <= 1'b1;
      end else if (move) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;

  localparam int WIDTH = 16;
  localparam int LW    = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LW-1:0]    load_len;
  logic             seq_out;
  logic             bit_valid;
  logic             word_last;
  logic             busy;
  logic [7:0]       words_sent;

  int checks   = 0;
  int failures = 0;
  int ws_exp   = 0;

  seq_serializer #(.WIDTH(WIDTH), .LW(LW), .IDLE_BIT(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .seq_out    (seq_out),
    .bit_valid  (bit_valid),
    .word_last  (word_last),
    .busy       (busy),
    .words_sent (words_sent)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic so, input logic bv, input logic wl);
    chk({tag, ".seq_out"}, {31'd0, seq_out}, {31'd0, so});
    chk({tag, ".bit_valid"}, {31'd0, bit_valid}, {31'd0, bv});
    chk({tag, ".word_last"}, {31'd0, word_last}, {31'd0, wl});
  endtask

  // data 0x0002, len 4: 0,0,1,0 on E1..E4, then idle
  task automatic word4_scenario(input string tag);
    logic [3:0] exp_bits;
    exp_bits = 4'b0010;
    load_valid = 1'b1; load_data = 16'h0002; load_len = 4'd4;
    step();                                         // E0: accept
    load_valid = 1'b0; load_data = 16'hFFFF;
    chk_bit({tag, ".e0"}, 1'b1, 1'b0, 1'b0);
    chk({tag, ".e0.busy"}, {31'd0, busy}, 32'd1);
    for (int i = 3; i >= 0; i--) begin
      step();
      chk_bit($sformatf("%s.bit%0d", tag, i), exp_bits[i], 1'b1, (i == 0));
    end
    ws_exp = (ws_exp + 1) % 256;
    step();
    chk_bit({tag, ".idle"}, 1'b1, 1'b0, 1'b0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".words_sent"}, {24'd0, words_sent}, ws_exp[31:0]);
  endtask

  initial begin
    logic [3:0]  ab_bits;
    logic [3:0]  ab_last;
    logic [15:0] long_word;
    logic [7:0]  c_word;
    int          base;

    reset = 1'b1; flush = 1'b0; load_valid = 1'b0;
    load_data = '0; load_len = '0;
    step(); step();
    chk_bit("reset", 1'b1, 1'b0, 1'b0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.words_sent", {24'd0, words_sent}, 32'd0);
    reset = 1'b0;
    #1;
    chk("reset.load_ready", {31'd0, load_ready}, 32'd1);

    // Scenario 1: single 4-bit word
    word4_scenario("s1");

    // Scenario 2: back to back, A=101 (len 3), B=11 (len 2)
    load_valid = 1'b1; load_data = 16'h0005; load_len = 4'd3;
    step();                                         // E0: accept A
    load_data = 16'h0003; load_len = 4'd2;
    chk("s2.ready_e0", {31'd0, load_ready}, 32'd1);
    step();                                         // E1: A transfers, B accepted
    load_valid = 1'b0;
    chk("s2.ready_e1", {31'd0, load_ready}, 32'd0);
    chk_bit("s2.e1", 1'b1, 1'b1, 1'b0);
    ab_bits = 4'b0111;  // E2..E5, listed from E2 at bit 3
    ab_last = 4'b0101;
    for (int i = 3; i >= 0; i--) begin
      step();
      chk_bit($sformatf("s2.e%0d", 5 - i), ab_bits[i], 1'b1, ab_last[i]);
      if (i == 3) chk("s2.ready_e2", {31'd0, load_ready}, 32'd0);
    end
    ws_exp = (ws_exp + 2) % 256;
    step();
    chk_bit("s2.idle", 1'b1, 1'b0, 1'b0);
    chk("s2.words_sent", {24'd0, words_sent}, ws_exp[31:0]);

    // Scenario 3: len 0 = 16 bits, 0x8001
    long_word = 16'h8001;
    load_valid = 1'b1; load_data = long_word; load_len = 4'd0;
    step();
    load_valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      step();
      chk_bit($sformatf("s3.bit%0d", i), long_word[i], 1'b1, (i == 0));
    end
    ws_exp = (ws_exp + 1) % 256;
    step();
    chk_bit("s3.idle", 1'b1, 1'b0, 1'b0);
    chk("s3.words_sent", {24'd0, words_sent}, ws_exp[31:0]);

    // Scenario 4: stream of 1-bit words, alternating data
    base = ws_exp;
    load_valid = 1'b1; load_len = 4'd1;
    for (int k = 0; k < 8; k++) begin
      load_data = 16'(k & 1);
      step();                                       // edge E_k
      chk($sformatf("s4.ready%0d", k), {31'd0, load_ready}, 32'd1);
      if (k >= 1) begin
        chk_bit($sformatf("s4.e%0d", k), 1'((k - 1) & 1), 1'b1, 1'b1);
        chk($sformatf("s4.ws%0d", k), {24'd0, words_sent}, 32'((base + k - 1) % 256));
      end
    end
    load_valid = 1'b0;
    step();                                         // E8: last word d7=1
    chk_bit("s4.e8", 1'b1, 1'b1, 1'b1);
    step();
    chk_bit("s4.idle", 1'b1, 1'b0, 1'b0);
    ws_exp = (base + 8) % 256;
    chk("s4.words_sent", {24'd0, words_sent}, ws_exp[31:0]);

    // Scenario 5: flush on the 3rd bit of an 8-bit word with one pending
    c_word = 8'hA5;
    load_valid = 1'b1; load_data = 16'(c_word); load_len = 4'd8;
    step();                                         // E0: accept C
    load_data = 16'h0003; load_len = 4'd2;
    step();                                         // E1: C transfers, D accepted
    load_valid = 1'b0;
    chk_bit("s5.e1", c_word[7], 1'b1, 1'b0);
    step();
    chk_bit("s5.e2", c_word[6], 1'b1, 1'b0);
    step();
    chk_bit("s5.e3", c_word[5], 1'b1, 1'b0);
    flush = 1'b1; load_valid = 1'b1;
    #1;
    chk("s5.ready_flush", {31'd0, load_ready}, 32'd0);
    step();                                         // flush sampled
    flush = 1'b0; load_valid = 1'b0;
    chk_bit("s5.flushed", 1'b1, 1'b0, 1'b0);
    chk("s5.busy", {31'd0, busy}, 32'd0);
    chk("s5.words_sent", {24'd0, words_sent}, ws_exp[31:0]);
    step();
    chk_bit("s5.after", 1'b1, 1'b0, 1'b0);
    chk("s5.ready_after", {31'd0, load_ready}, 32'd1);

    // Scenario 6: async reset mid-word, then a fresh word
    load_valid = 1'b1; load_data = 16'h0002; load_len = 4'd4;
    step();
    load_valid = 1'b0;
    step();
    step();                                         // bit2=0 on seq_out
    chk_bit("s6.pre", 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_bit("s6.reset", 1'b1, 1'b0, 1'b0);
    chk("s6.busy", {31'd0, busy}, 32'd0);
    chk("s6.words_sent", {24'd0, words_sent}, 32'd0);
    step();
    reset = 1'b0;
    ws_exp = 0;
    step();
    chk_bit("s6.released", 1'b1, 1'b0, 1'b0);
    chk("s6.busy_released", {31'd0, busy}, 32'd0);
    word4_scenario("s6w");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
